fp_div_nr: RTL and testbench

Iterative single-precision floating-point divider computing quot = opa / opb. It uses a magic-number reciprocal seed, NR_ITERS Newton-Raphson refinements y ← y·(2 − b·y), and a final multiply by the dividend. The block is the reciprocal-direction companion to the fast inverse-square-root pipeline in the FPU. It shares the FPU's truncating, flush-to-zero multiplier semantics, and it exchanges operands through a valid/ready handshake instead of a free-running pipeline.

---
 rtl/fp_div_nr_pkg.sv | 8 +
 rtl/fp_mul_trunc.sv | 15 +
 rtl/fp_div_nr.sv | 115 +++++++++++
 tb/tb_fp_div_nr.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_nr_pkg.sv
// fp_div_pkg: state type and constants shared by the fp_div_nr divider
package fp_div_pkg;
   typedef enum logic [2:0] {IDLE, SEED, MUL1, SUB, MUL2, FINAL, DONE} state_t;
   localparam logic [31:0] MAGIC_RECIP = 32'h7EF311C7;
   localparam logic [31:0] FP_ONE = 32'h3F800000;
   localparam logic [30:0] FP_INF_MAG = 31'h7F800000;
   localparam int CNT_W = 3;
endpackage

// File: rtl/fp_mul_trunc.sv
// fp_mul_trunc: combinational single-precision multiply, truncating and flush-to-zero
module fp_mul_trunc (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] p
);
   logic [24:0] top;
   logic [8:0] esum;
   always_comb begin
      top = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);
      esum = {1'b0, a[30:23]} + {1'b0, b[30:23]} + {8'd0, top[24]};
      p = (a[30:23] == 8'd0 || b[30:23] == 8'd0 || esum <= 9'd127) ? 32'd0 :
          {a[31] ^ b[31], 8'(esum - 9'd127), top[24] ? top[23:1] : top[22:0]};
   end
endmodule

// File: rtl/fp_div_nr.sv
// fp_div_nr: iterative Newton-Raphson FP divider with valid/ready handshake
// FP_DIV_RECIP_OUT_EN adds the refined reciprocal output port recip
module fp_div_nr
   import fp_div_pkg::*;
#(
   parameter int NR_ITERS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quot,
   output logic        dbz
`ifdef FP_DIV_RECIP_OUT_EN
   ,
   output logic [31:0] recip
`endif
);
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic sign, accept;
   logic [30:0] a_mag, b_mag, p;
   logic [31:0] y, t, t_next, ma, mb, m_out;
   logic [25:0] fx, d;
   logic [4:0] k;
   assign accept = in_valid && in_ready;
   always_comb begin
      ma = state == MUL1 ? {1'b0, b_mag} : state == MUL2 ? y : {1'b0, a_mag};
      mb = state == MUL2 ? t : y;
   end
   fp_mul_trunc u_mul (.a(ma), .b(mb), .p(m_out));
   // 2 - p in Q1.24, renormalised through a leading-one detect
   always_comb begin
      fx = p[23] ? {2'b01, p[22:0], 1'b0} : {3'b001, p[22:0]};
      d = 26'h2000000 - fx;
      k = '0;
      for (int i = 0; i < 26; i++) if (d[i]) k = 5'(i);
      t_next = (p[30:24] == 7'h3F) ? {1'b0, 8'd103 + {3'd0, k}, 23'((d << (5'd25 - k)) >> 2)} : FP_ONE;
   end
`ifdef FP_DIV_RECIP_OUT_EN
   logic sign_b;
   always_ff @(posedge clk) begin
      if (accept) sign_b <= opb[31];
      if (!rst_n) recip <= '0;
      else if (state == FINAL) recip <= {sign_b, y[30:0]};
   end
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         in_ready <= 1'b0;
         out_valid <= 1'b0;
         quot <= '0;
         dbz <= 1'b0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= !accept;
               if (accept) begin
                  a_mag <= opa[30:0];
                  b_mag <= opb[30:0];
                  sign <= opa[31] ^ opb[31];
                  cnt <= '0;
                  if (opb[30:23] == 8'd0) begin
                     quot <= {opa[31] ^ opb[31], FP_INF_MAG};
                     dbz <= 1'b1;
                     state <= DONE;
                  end else if (opa[30:23] == 8'd0) begin
                     quot <= '0;
                     dbz <= 1'b0;
                     state <= DONE;
                  end else state <= SEED;
               end
            end
            SEED: begin
               y <= MAGIC_RECIP - {1'b0, b_mag};
               state <= MUL1;
            end
            MUL1: begin
               p <= m_out[30:0];
               state <= SUB;
            end
            SUB: begin
               t <= t_next;
               state <= MUL2;
            end
            MUL2: begin
               y <= m_out;
               cnt <= cnt + 1'b1;
               state <= (32'(cnt) + 1 < NR_ITERS) ? MUL1 : FINAL;
            end
            FINAL: begin
               quot <= (m_out[30:0] == 31'd0) ? '0 : {sign ^ m_out[31], m_out[30:0]};
               dbz <= 1'b0;
               out_valid <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               if (!out_valid) out_valid <= 1'b1;
               else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_div_nr.sv
// tb_fp_div_nr: directed bench for fp_div_nr with a real-arithmetic reference model
module tb_fp_div_nr;
   localparam int NR = 3;
   localparam logic [31:0] MAGIC = 32'h7EF311C7;
   typedef struct {
      logic [31:0] q;
      logic        dbz;
      logic [31:0] r;
      int          lat;
      int          acc;
   } exp_t;
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid, dbz;
   logic [31:0] opa = 0, opb = 0, quot;
`ifdef FP_DIV_RECIP_OUT_EN
   logic [31:0] recip;
`endif
   int total = 0, bad = 0, cyc = 0;
   exp_t sb[$];
   exp_t m_e, bp_e;
   logic ov_d = 0;
   logic [31:0] va [10] = '{32'h3F800000, 32'h41200000, 32'hC0B00000, 32'h501502F9, 32'h00800000,
                            32'h80800000, 32'h3FFFFFFF, 32'h42F6E979, 32'h40400000, 32'h80000000};
   logic [31:0] vb [10] = '{32'h40400000, 32'h40E00000, 32'hC0000000, 32'h37FBA882, 32'h7E000000,
                            32'h7E000000, 32'h3F800001, 32'hC2F6E979, 32'h80000001, 32'h00000000};

   always #5 clk = ~clk;

   fp_div_nr #(.NR_ITERS(NR)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opa(opa), .opb(opb), .out_valid(out_valid), .out_ready(out_ready),
      .quot(quot), .dbz(dbz)
`ifdef FP_DIV_RECIP_OUT_EN
      , .recip(recip)
`endif
   );

   function automatic real f2r(logic [31:0] x);
      real m;
      int e;
      if (x[30:23] == 8'd0) return 0.0;
      m = 1.0 + $itor(x[22:0]) / 8388608.0;
      e = int'(x[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2f(real r);
      real m;
      int e;
      logic [22:0] f;
      if (r <= 0.0) return 32'd0;
      e = 127;
      m = r;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      if (e <= 0) return 32'd0;
      m = m - 1.0;
      f = '0;
      for (int i = 22; i >= 0; i--) begin
         m = m * 2.0;
         if (m >= 1.0) begin f[i] = 1'b1; m = m - 1.0; end
      end
      return {1'b0, e[7:0], f};
   endfunction

   function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
      return r2f(f2r(a) * f2r(b));
   endfunction

   function automatic exp_t model(logic [31:0] a, logic [31:0] b);
      exp_t e;
      logic [31:0] y, p, t, pq;
      logic s;
      s = a[31] ^ b[31];
      e.r = '0;
      e.acc = 0;
      e.dbz = 1'b0;
      if (b[30:23] == 8'd0) begin
         e.q = {s, 31'h7F800000}; e.dbz = 1'b1; e.lat = 1;
      end else if (a[30:23] == 8'd0) begin
         e.q = '0; e.lat = 1;
      end else begin
         y = MAGIC - {1'b0, b[30:0]};
         for (int i = 0; i < NR; i++) begin
            p = fmul({1'b0, b[30:0]}, y);
            t = (p[30:23] == 8'd126 || p[30:23] == 8'd127) ? r2f(2.0 - f2r(p)) : 32'h3F800000;
            y = fmul(y, t);
         end
         pq = fmul({1'b0, a[30:0]}, y);
         e.q = (pq == 32'd0) ? 32'd0 : {s, pq[30:0]};
         e.r = {b[31], y[30:0]};
         e.lat = 2 + 3 * NR;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic ulp_chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      logic [31:0] dd;
      dd = act > expv ? act - expv : expv - act;
      total++;
      if (dd > 32'd8) begin
         bad++;
         $display("FAIL %s: got %h want %h within 8 ulp", nm, act, expv);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
      end
      opa = a;
      opb = b;
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic wait_out();
      int n = 0;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      if (!out_valid) begin
         total++; bad++;
         $display("FAIL out_timeout: out_valid=%b want 1", out_valid);
      end
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) sb.delete();
      else begin
         if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
         if (in_valid && in_ready) begin
            m_e = model(opa, opb);
            m_e.acc = cyc;
            sb.push_back(m_e);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out: quot=%h with no pending request", quot);
         end else begin
            chk("quot", quot, sb[0].q);
            chk("dbz", {31'd0, dbz}, {31'd0, sb[0].dbz});
`ifdef FP_DIV_RECIP_OUT_EN
            if (sb[0].lat > 1) chk("recip", recip, sb[0].r);
`endif
            if (!ov_d) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
         end
      end
      ov_d = out_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_quot", quot, 32'd0);
      chk("rst_dbz", {31'd0, dbz}, 32'd0);
`ifdef FP_DIV_RECIP_OUT_EN
      chk("rst_recip", recip, 32'd0);
`endif
      rst_n = 1;
      @(negedge clk);
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
      // 6 / 3
      send(32'h40C00000, 32'h40400000);
      wait_out();
      ulp_chk("six_by_three", quot, 32'h40000000);
      chk("six_by_three_dbz", {31'd0, dbz}, 32'd0);
      @(negedge clk);
      // -1 / 4
      send(32'hBF800000, 32'h40800000);
      wait_out();
      ulp_chk("neg_quarter", quot, 32'hBE800000);
`ifdef FP_DIV_RECIP_OUT_EN
      ulp_chk("neg_quarter_recip", recip, 32'h3E800000);
`endif
      @(negedge clk);
      send(32'hBF800000, 32'h00000000);
      wait_out();
      chk("div_zero_quot", quot, 32'hFF800000);
      chk("div_zero_dbz", {31'd0, dbz}, 32'd1);
      @(negedge clk);
      send(32'h00000000, 32'h40400000);
      wait_out();
      chk("zero_num_quot", quot, 32'h00000000);
      chk("zero_num_dbz", {31'd0, dbz}, 32'd0);
      @(negedge clk);
      send(32'h00000000, 32'h00000000);
      wait_out();
      chk("zero_zero_quot", quot, 32'h7F800000);
      chk("zero_zero_dbz", {31'd0, dbz}, 32'd1);
      @(negedge clk);
      // back-pressure with a busy-time request that must be dropped
      bp_e = model(32'h40C00000, 32'h40400000);
      out_ready = 0;
      send(32'h40C00000, 32'h40400000);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         opa = 32'h3F800000;
         opb = 32'h40400000;
         in_valid = 1;
         @(negedge clk);
         chk("bp_quot", quot, bp_e.q);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 0;
      out_ready = 1;
      @(negedge clk);
      chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
      chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (15) @(negedge clk);
      chk("no_ghost_out", {31'd0, out_valid}, 32'd0);
      // reset while in MUL1
      send(32'h40C00000, 32'h40400000);
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_quot", quot, 32'd0);
      chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1;
      @(negedge clk);
      chk("mrst_rel_in_ready", {31'd0, in_ready}, 32'd1);
      send(32'h40C00000, 32'h40400000);
      wait_out();
      ulp_chk("after_rst_six_by_three", quot, 32'h40000000);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         send(va[i], vb[i]);
         wait_out();
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
